// File: rtl/wb_merge_queue.sv
// wb_merge_queue: write-back merge stage in front of the register file.
// Accepts ALU and load results (round-robin when both are offered) and
// queues them in accept order. It drains one entry per cycle into the
// single register-file write port.
// Optional build macro WB_FWD_EN enables the combinational forwarding
// lookups (fwd_hit*/fwd_data*). Without it those outputs are tied to zero.
module wb_merge_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_W-1:0]          lsu_addr,
  input  logic [DATA_W-1:0]          lsu_data,
  input  logic                       rf_hold,
  output logic                       rf_write,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  input  logic [ADDR_W-1:0]          fwd_addr1,
  input  logic [ADDR_W-1:0]          fwd_addr2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_lsu_q, last_lsu_d;   // 0: ALU granted last, 1: LSU

  logic              acc_alu;
  logic              acc_lsu;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Ready depends only on full; a same-cycle drain never frees a slot early.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!full) begin
      if (alu_valid && lsu_valid) begin
        alu_ready = last_lsu_q;
        lsu_ready = !last_lsu_q;
      end else begin
        alu_ready = 1'b1;
        lsu_ready = 1'b1;
      end
    end
  end

  assign acc_alu = alu_valid && alu_ready;
  assign acc_lsu = lsu_valid && lsu_ready;
  assign push    = acc_alu || acc_lsu;
  assign in_addr = acc_lsu ? lsu_addr : alu_addr;
  assign in_data = acc_lsu ? lsu_data : alu_data;

  // Head entry is presented straight from storage; it pops on the write edge.
  always_comb begin
    rf_write = !empty && !rf_hold;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!empty) begin
      rf_waddr = addr_q[rd_ptr_q];
      rf_wdata = data_q[rd_ptr_q];
    end
  end

  assign pop = rf_write;

  // Next-state for pointers, occupancy and round-robin history.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    last_lsu_d = last_lsu_q;
    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      last_lsu_d = acc_lsu;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards every pending entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      last_lsu_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      last_lsu_q <= last_lsu_d;
    end
  end

  // Entry storage written at the tail on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr_q] <= in_addr;
      data_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef WB_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest match overwrites older ones;
  // the head being drained this cycle is still occupied and can hit.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (addr_q[fwd_idx] == fwd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[fwd_idx];
        end
        if (addr_q[fwd_idx] == fwd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[fwd_idx];
        end
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{fwd_addr1, fwd_addr2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_wb_merge_queue.sv
// Testbench for wb_merge_queue: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_wb_merge_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid, lsu_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_data;
  logic              rf_hold;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] fwd_addr1, fwd_addr2;
  logic              fwd_hit1, fwd_hit2;
  logic [DATA_W-1:0] fwd_data1, fwd_data2;
  logic [2:0]        count;
  logic              full, empty;

  wb_merge_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .rf_hold(rf_hold), .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t mq[$];          // reference queue, index 0 = oldest
  bit   m_last_lsu;     // round-robin history of the reference model
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void fwd_model(input logic [ADDR_W-1:0] fa, output logic hit,
                                    output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (mq[i]) begin
      if (mq[i].a == fa) begin
        hit = 1'b1;
        d   = mq[i].d;
      end
    end
`ifndef WB_FWD_EN
    hit = 1'b0;
    d   = '0;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_rf_write"}, rf_write, 0);
    chk({tag, "_rf_waddr"}, rf_waddr, 0);
    chk({tag, "_rf_wdata"}, rf_wdata, 0);
    chk({tag, "_fwd_hit"}, {fwd_hit1, fwd_hit2}, 0);
    chk({tag, "_fwd_data"}, {fwd_data1, fwd_data2}, 0);
  endtask

  // One cycle: drive at negedge, compare against the model, then advance it.
  task automatic step(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                      input logic hold, input logic [ADDR_W-1:0] f1, input logic [ADDR_W-1:0] f2,
                      output bit ga, output bit gl);
    bit                ful, wr;
    logic              eh1, eh2;
    logic [DATA_W-1:0] ed1, ed2;
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    rf_hold = hold; fwd_addr1 = f1; fwd_addr2 = f2;
    #1;
    ful = (mq.size() == DEPTH);
    if (ful) begin
      ga = 0; gl = 0;
    end else if (av && lv) begin
      gl = !m_last_lsu;
      ga = m_last_lsu;
    end else begin
      ga = av; gl = lv;
    end
    wr = (mq.size() != 0) && !hold;
    chk("alu_accept", alu_valid && alu_ready, ga);
    chk("lsu_accept", lsu_valid && lsu_ready, gl);
    if (ful) chk("ready_when_full", {alu_ready, lsu_ready}, 0);
    chk("count", count, mq.size());
    chk("full", full, ful);
    chk("empty", empty, mq.size() == 0);
    chk("rf_write", rf_write, wr);
    chk("rf_waddr", rf_waddr, (mq.size() != 0) ? mq[0].a : 0);
    chk("rf_wdata", rf_wdata, (mq.size() != 0) ? mq[0].d : 0);
    fwd_model(f1, eh1, ed1);
    fwd_model(f2, eh2, ed2);
    chk("fwd_hit1", fwd_hit1, eh1);
    chk("fwd_data1", fwd_data1, ed1);
    chk("fwd_hit2", fwd_hit2, eh2);
    chk("fwd_data2", fwd_data2, ed2);
    if (wr) void'(mq.pop_front());
    if (ga) begin mq.push_back('{a: aa, d: ad}); m_last_lsu = 0; end
    if (gl) begin mq.push_back('{a: la, d: ld}); m_last_lsu = 1; end
  endtask

  task automatic idle(input logic hold, input int n);
    bit ga, gl;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, hold, 5, 7, ga, gl);
  endtask

  task automatic reset_now(input string tag);
    @(negedge clk);
    alu_valid = 0; lsu_valid = 0; rf_hold = 0;
    rst = 1;
    #1;
    mq.delete();
    m_last_lsu = 0;
    check_reset_outputs(tag);
    @(negedge clk);
    rst = 0;
  endtask

  bit                ga, gl;
  bit                a_keep, l_keep;
  logic              pa_v, pl_v, hold_r;
  logic [ADDR_W-1:0] pa_a, pl_a, rf1, rf2;
  logic [DATA_W-1:0] pa_d, pl_d;

  initial begin
    rst = 1;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
    rf_hold = 0; fwd_addr1 = 0; fwd_addr2 = 0;
    m_last_lsu = 0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 0;

    // Single ALU result, written the following cycle, then empty.
    step(1, 3, 32'h11, 0, 0, 0, 0, 3, 7, ga, gl);
    idle(0, 2);

    // Both sources every cycle under hold: LSU, ALU, LSU, ALU, then full.
    step(1, 5, 32'hB, 1, 5, 32'hA, 1, 5, 7, ga, gl);
    step(1, 5, 32'hB, 1, 6, 32'hC, 1, 5, 7, ga, gl);
    step(1, 8, 32'hD, 1, 6, 32'hC, 1, 5, 7, ga, gl);
    step(1, 8, 32'hD, 1, 9, 32'hE, 1, 5, 7, ga, gl);
    step(1, 8, 32'hF, 1, 9, 32'hE, 1, 5, 7, ga, gl);
    step(1, 8, 32'hF, 1, 9, 32'hE, 1, 6, 8, ga, gl);

    // Release hold: four back-to-back writes in accept order.
    idle(0, 5);

    // Steady state: one accept and one drain per cycle, pointers wrap.
    step(1, 1, 32'h100, 0, 0, 0, 0, 1, 2, ga, gl);
    for (int i = 0; i < 10; i++)
      step(1, ADDR_W'(i + 2), 32'h200 + i, 0, 0, 0, 0, ADDR_W'(i + 1), 2, ga, gl);
    idle(0, 2);

    // Reset with three entries pending, then no stale writes.
    step(1, 4, 32'h41, 0, 0, 0, 1, 4, 7, ga, gl);
    step(0, 0, 0, 1, 4, 32'h42, 1, 4, 7, ga, gl);
    step(1, 6, 32'h43, 0, 0, 0, 1, 4, 7, ga, gl);
    reset_now("mid_reset");
    idle(0, 3);

    // Randomized traffic; producers hold an offered result until accepted.
    a_keep = 0; l_keep = 0;
    pa_v = 0; pa_a = 0; pa_d = 0; pl_v = 0; pl_a = 0; pl_d = 0;
    for (int n = 0; n < 400; n++) begin
      if (!a_keep) begin
        pa_v = ($urandom_range(0, 2) != 0);
        pa_a = ADDR_W'($urandom_range(0, 7));
        pa_d = $urandom;
      end
      if (!l_keep) begin
        pl_v = ($urandom_range(0, 2) != 0);
        pl_a = ADDR_W'($urandom_range(0, 7));
        pl_d = $urandom;
      end
      hold_r = ($urandom_range(0, 3) == 0);
      rf1 = ADDR_W'($urandom_range(0, 7));
      rf2 = ADDR_W'($urandom_range(0, 7));
      step(pa_v, pa_a, pa_d, pl_v, pl_a, pl_d, hold_r, rf1, rf2, ga, gl);
      a_keep = pa_v && !ga;
      l_keep = pl_v && !gl;
    end
    idle(0, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
